tqv_pulse_generator: RTL and testbench
======================================

Name: tqv_pulse_generator

Overview:
- TinyQV peripheral that transmits programmable pulse trains on uo_out[0]. It is the transmit-side counterpart of the edge counter.
- The CPU configures high time, low time and pulse count over the TinyQV peripheral bus, then starts the train by register write or by an external trigger on ui_in[0].
- Produces a sticky DONE flag and an optional interrupt. Used for self-test loops into the edge counter and for driving external logic.

Parameters:
- CNT_W, 16, width of the HIGH_TIME, LOW_TIME, COUNT and REMAINING registers and of the internal counters.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- ui_in  in  8  bit0 = external trigger (asynchronous); bits 7:1 unused.
- uo_out  out  8  bit0 = pulse output, bit1 = busy, bits 7:2 = 0.
- address  in  6  byte address of register.
- data_in  in  32  write data.
- data_write_n  in  2  11 = no write, 00 = byte, 01 = halfword, 10 = word.
- data_read_n  in  2  11 = no read, other values = read of that width.
- data_out  out  32  read data.
- data_ready  out  1  constant 1; all accesses complete in one cycle.
- user_interrupt  out  1  DONE & IRQ_EN.

Behaviour:
- Registers; byte/halfword writes update only bits [7:0] / [15:0]:
  - 0x00 CTRL:
    - W bit0 START (self-clearing), bit1 STOP, bit4 DONE_CLR.
    - R/W bit2 IDLE_LEVEL, bit3 IRQ_EN, bit5 TRIG_EN.
    - R bit8 BUSY, bit9 DONE.
  - 0x04 HIGH_TIME, 0x08 LOW_TIME, 0x0C COUNT: R/W, CNT_W bits.
  - 0x10 REMAINING: read-only.
  - Unmapped addresses read 0 and ignore writes.
- Reads: data_out is combinational from address. Unused bits read 0.
- Reset: all registers 0, FSM IDLE, DONE=0, sync flops 0, uo_out=0x00, user_interrupt=0, data_out=0 for address 0.
- FSM states: IDLE, HIGH, LOW. Active level = ~IDLE_LEVEL. Pulse output is registered and equals the active level only in HIGH.
- Start sources:
  - START write at rising edge k.
  - Trigger, when TRIG_EN=1: ui_in[0] passes through a 2-FF synchronizer, and a rising edge of the synchronized signal starts the train. A pin rising edge starts the train 3 clocks later.
- Start action, in IDLE only:
  - Enter HIGH at the accepting edge.
  - Load phase timer with max(HIGH_TIME,1).
  - Load REMAINING with COUNT.
  - Clear DONE.
  - Pulse is active for exactly max(HIGH_TIME,1) cycles, beginning with the cycle after the accepting edge.
- HIGH end (timer reaches 1):
  - COUNT=0 (continuous): go to LOW.
  - Else decrement REMAINING. If it becomes 0, go to IDLE and set DONE. Otherwise go to LOW.
- LOW end: after max(LOW_TIME,1) cycles, reload the timer with max(HIGH_TIME,1) and go to HIGH.
- HIGH_TIME and LOW_TIME are sampled at each phase load. Writes mid-run affect the next phase, not the current one.
- COUNT is sampled only at start. REMAINING never wraps; it stays 0 in continuous mode.
- Simultaneous events:
  - START while BUSY: ignored; the trigger is likewise ignored.
  - STOP: go to IDLE at the next edge with output at idle level; DONE unchanged. STOP in IDLE has no effect.
  - START+STOP in the same write: STOP wins, no pulse.
  - DONE_CLR together with a DONE-setting event: set wins.
  - START with DONE_CLR: DONE=0.
- IDLE_LEVEL change mid-run takes effect on the next cycle; the FSM is unaffected.
- BUSY = (state != IDLE), mirrored on uo_out[1].
- Asynchronous reset mid-train forces uo_out[0]=0 immediately.

Test Plan:
- Reset with ui_in=0 -> uo_out=0x00, all register reads 0, user_interrupt=0, data_ready=1.
- HIGH=3, LOW=2, COUNT=4, START at edge k -> uo_out[0] high exactly in cycles k+1..k+3, k+6..k+8, k+11..k+13, k+16..k+18. BUSY low from k+19, DONE=1, REMAINING=0.
- IRQ_EN=1, HIGH=1, LOW=1, COUNT=1 -> single 1-cycle pulse then user_interrupt=1. Write DONE_CLR -> user_interrupt=0 next cycle.
- COUNT=0, HIGH=0, LOW=0 -> continuous 1-high/1-low toggling. STOP after 10 pulses -> output 0 next cycle, DONE=0. START+STOP in the same write -> no pulse.
- IDLE_LEVEL=1, TRIG_EN=1, HIGH=5, COUNT=2, ui_in[0] rising edge -> uo_out[0] low 5 cycles starting 3 clocks after the pin edge. A second ui_in[0] edge during the train is ignored.
- Byte write 0xAB to HIGH_TIME holding 0x1234 -> reads 0x12AB. START during BUSY -> no restart, REMAINING keeps counting down.

Source files
------------

// File: rtl/tqv_pulse_generator.sv
// tqv_pulse_generator: TinyQV peripheral emitting programmable pulse trains on uo_out[0].
// Start comes from a CTRL write or a synchronized rising edge on ui_in[0].
module tqv_pulse_generator #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] high_time_q, high_time_d, low_time_q, low_time_d;
    logic [CNT_W-1:0] count_q, count_d, rem_q, rem_d, timer_q, timer_d;
    logic             idle_level_q, idle_level_d, irq_en_q, irq_en_d, trig_en_q, trig_en_d;
    logic             done_q, done_d, pulse_q, pulse_d, trig_prev_q, trig_prev_d;
    logic [1:0]       sync_q, sync_d;
    logic             wr, ctrl_wr, busy, trig_edge, go, stop_req;
    logic [31:0]      wmask;
    logic [CNT_W-1:0] m, wbits, high_ld, low_ld;
    logic             unused_ok;
    assign wr        = data_write_n != 2'b11;
    assign wmask     = (data_write_n == 2'b00) ? 32'hFF : (data_write_n == 2'b01) ? 32'hFFFF : '1;
    assign m         = wmask[CNT_W-1:0];
    assign wbits     = data_in[CNT_W-1:0] & m;
    assign ctrl_wr   = wr && address == 6'h00;
    assign busy      = state_q != IDLE;
    assign trig_edge = trig_en_q && sync_q[1] && !trig_prev_q;
    // STOP in the same write suppresses a START even from IDLE
    assign go        = !busy && ((ctrl_wr && data_in[0]) || trig_edge) && !(ctrl_wr && data_in[1]);
    assign stop_req  = ctrl_wr && data_in[1] && busy;
    assign high_ld   = (high_time_q == '0) ? CNT_W'(1) : high_time_q;
    assign low_ld    = (low_time_q == '0) ? CNT_W'(1) : low_time_q;
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        rem_d        = rem_q;
        done_d       = done_q;
        high_time_d  = high_time_q;
        low_time_d   = low_time_q;
        count_d      = count_q;
        idle_level_d = idle_level_q;
        irq_en_d     = irq_en_q;
        trig_en_d    = trig_en_q;
        sync_d       = {sync_q[0], ui_in[0]};
        trig_prev_d  = sync_q[1];
        if (ctrl_wr) begin
            idle_level_d = data_in[2];
            irq_en_d     = data_in[3];
            trig_en_d    = data_in[5];
            if (data_in[4]) done_d = 1'b0;
        end
        if (wr && address == 6'h04) high_time_d = (high_time_q & ~m) | wbits;
        if (wr && address == 6'h08) low_time_d  = (low_time_q & ~m) | wbits;
        if (wr && address == 6'h0C) count_d     = (count_q & ~m) | wbits;
        if (go) begin
            state_d = HIGH;
            timer_d = high_ld;
            rem_d   = count_q;
            done_d  = 1'b0;
        end else if (stop_req) begin
            state_d = IDLE;
        end else if (busy) begin
            if (timer_q != CNT_W'(1)) begin
                timer_d = timer_q - CNT_W'(1);
            end else if (state_q == LOW) begin
                state_d = HIGH;
                timer_d = high_ld;
            end else if (rem_q == '0) begin
                state_d = LOW;
                timer_d = low_ld;
            end else begin
                // REMAINING is only nonzero while running in counted mode
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LOW;
                    timer_d = low_ld;
                end
            end
        end
        pulse_d = idle_level_d ^ (state_d == HIGH);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            rem_q        <= '0;
            done_q       <= 1'b0;
            high_time_q  <= '0;
            low_time_q   <= '0;
            count_q      <= '0;
            idle_level_q <= 1'b0;
            irq_en_q     <= 1'b0;
            trig_en_q    <= 1'b0;
            pulse_q      <= 1'b0;
            sync_q       <= '0;
            trig_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rem_q        <= rem_d;
            done_q       <= done_d;
            high_time_q  <= high_time_d;
            low_time_q   <= low_time_d;
            count_q      <= count_d;
            idle_level_q <= idle_level_d;
            irq_en_q     <= irq_en_d;
            trig_en_q    <= trig_en_d;
            pulse_q      <= pulse_d;
            sync_q       <= sync_d;
            trig_prev_q  <= trig_prev_d;
        end
    end
    always_comb begin
        data_out = '0;
        case (address)
            6'h00:   data_out = {22'b0, done_q, busy, 2'b0, trig_en_q, 1'b0, irq_en_q, idle_level_q, 2'b0};
            6'h04:   data_out = 32'(high_time_q);
            6'h08:   data_out = 32'(low_time_q);
            6'h0C:   data_out = 32'(count_q);
            6'h10:   data_out = 32'(rem_q);
            default: data_out = '0;
        endcase
    end
    assign uo_out         = {6'b0, busy, pulse_q};
    assign data_ready     = 1'b1;
    assign user_interrupt = done_q & irq_en_q;
    assign unused_ok      = &{1'b0, ui_in[7:1], data_read_n, data_in, wmask};
endmodule

// File: tb/tb_tqv_pulse_generator.sv
// tb_tqv_pulse_generator: directed stimulus feeding a scoreboard of expected pin and read values.
module tb_tqv_pulse_generator;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  ui_in = 8'h00;
    logic [7:0]  uo_out;
    logic [5:0]  address = 6'h00;
    logic [31:0] data_in = 32'h0;
    logic [1:0]  data_write_n = 2'b11, data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready, user_interrupt;
    int          checks = 0, errors = 0;
    typedef struct {string n; logic [31:0] v;} exp_t;
    exp_t pin_q[$], rd_q[$];
    tqv_pulse_generator dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out), .address(address),
        .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
    );
    always #5 clk = ~clk;
    // Monitor: pin expectations are consumed one per cycle, read expectations on each read strobe
    always @(negedge clk) begin
        exp_t e;
        if (pin_q.size() > 0) begin
            e = pin_q.pop_front();
            checks++;
            if ({user_interrupt, uo_out} !== e.v[8:0]) begin
                errors++;
                $display("FAIL %s irq_uo got %h want %h", e.n, {user_interrupt, uo_out}, e.v[8:0]);
            end
        end
        if (data_read_n != 2'b11) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got %h want none", data_out);
            end else begin
                e = rd_q.pop_front();
                if (data_out !== e.v || data_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s data got %h rdy %b want %h rdy 1", e.n, data_out, data_ready, e.v);
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pins(input string n, input logic [8:0] v);
        pin_q.push_back('{n, {23'b0, v}});
    endtask
    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn = 2'b10);
        address = a;
        data_in = d;
        data_write_n = wn;
        tick();
        data_write_n = 2'b11;
    endtask
    task automatic rd(input logic [5:0] a, input logic [31:0] v, input string n);
        address = a;
        data_read_n = 2'b10;
        rd_q.push_back('{n, v});
        tick();
        data_read_n = 2'b11;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
    initial begin
        pins("in_reset", 9'h000);
        tick();
        tick();
        rst_n = 1'b1;
        pins("after_reset", 9'h000);
        tick();
        rd(6'h00, 0, "rst_ctrl");
        rd(6'h04, 0, "rst_high");
        rd(6'h08, 0, "rst_low");
        rd(6'h0C, 0, "rst_count");
        rd(6'h10, 0, "rst_rem");
        // HIGH=3 LOW=2 COUNT=4: pulses in k+1..3, 6..8, 11..13, 16..18
        wr(6'h04, 3);
        wr(6'h08, 2);
        wr(6'h0C, 4);
        wr(6'h00, 32'h1);
        for (int i = 1; i <= 20; i++)
            pins("train4", (i <= 18) ? (((i - 1) % 5 < 3) ? 9'h003 : 9'h002) : 9'h000);
        repeat (20) tick();
        rd(6'h00, 32'h200, "train4_done");
        rd(6'h10, 0, "train4_rem");
        // single pulse with interrupt
        wr(6'h00, 32'h18);
        wr(6'h04, 1);
        wr(6'h08, 1);
        wr(6'h0C, 1);
        wr(6'h00, 32'h09);
        pins("single_pulse", 9'h003);
        pins("irq_set", 9'h100);
        pins("irq_set", 9'h100);
        pins("irq_set", 9'h100);
        repeat (3) tick();
        wr(6'h00, 32'h18);
        pins("irq_clr", 9'h000);
        tick();
        // continuous toggle, STOP during 10th pulse
        wr(6'h00, 0);
        wr(6'h04, 0);
        wr(6'h08, 0);
        wr(6'h0C, 0);
        wr(6'h00, 32'h1);
        for (int i = 1; i <= 19; i++) pins("cont", (i % 2 == 1) ? 9'h003 : 9'h002);
        repeat (18) tick();
        wr(6'h00, 32'h2);
        pins("stop", 9'h000);
        pins("stop", 9'h000);
        tick();
        tick();
        rd(6'h00, 0, "stop_ctrl");
        rd(6'h10, 0, "cont_rem");
        wr(6'h00, 32'h3);
        pins("start_stop", 9'h000);
        pins("start_stop", 9'h000);
        tick();
        tick();
        // inverted idle level, external trigger, second edge ignored
        wr(6'h04, 5);
        wr(6'h08, 2);
        wr(6'h0C, 2);
        wr(6'h00, 32'h24);
        for (int i = 1; i <= 17; i++)
            pins("trig", (i <= 3) ? 9'h001 : (i <= 8) ? 9'h002 : (i <= 10) ? 9'h003 :
                         (i <= 15) ? 9'h002 : 9'h001);
        ui_in = 8'h01;
        repeat (4) tick();
        ui_in = 8'h00;
        repeat (2) tick();
        ui_in = 8'h01;
        repeat (11) tick();
        ui_in = 8'h00;
        rd(6'h10, 0, "trig_rem");
        rd(6'h00, 32'h224, "trig_ctrl");
        // partial writes and unmapped address
        wr(6'h04, 32'h1234);
        wr(6'h04, 32'hAB, 2'b00);
        rd(6'h04, 32'h12AB, "byte_write");
        wr(6'h04, 32'hFFFF5678, 2'b01);
        rd(6'h04, 32'h5678, "half_write");
        wr(6'h14, 32'hFFFFFFFF);
        rd(6'h14, 0, "unmapped");
        // START while busy is ignored
        wr(6'h00, 0);
        wr(6'h04, 4);
        wr(6'h08, 1);
        wr(6'h0C, 3);
        wr(6'h00, 32'h1);
        for (int i = 1; i <= 16; i++)
            pins("busy_start", (i >= 15) ? 9'h000 : (i == 5 || i == 10) ? 9'h002 : 9'h003);
        tick();
        wr(6'h00, 32'h1);
        rd(6'h10, 3, "rem_3");
        repeat (2) tick();
        rd(6'h10, 2, "rem_2");
        repeat (10) tick();
        rd(6'h00, 32'h200, "busy_done");
        rd(6'h10, 0, "busy_rem");
        // asynchronous reset in the middle of a high phase
        wr(6'h00, 32'h1);
        pins("pre_reset", 9'h003);
        tick();
        rst_n = 1'b0;
        pins("async_reset", 9'h000);
        tick();
        rst_n = 1'b1;
        pins("post_reset", 9'h000);
        tick();
        rd(6'h00, 0, "post_ctrl");
        rd(6'h04, 0, "post_high");
        for (int i = 0; i < 50 && (pin_q.size() > 0 || rd_q.size() > 0); i++) tick();
        if (pin_q.size() > 0 || rd_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", pin_q.size() + rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
